// File: rtl/ppu_bus_pkg.sv
// PPU VRAM bus controller shared types.
// Bus FSM states, access owner and the latched access bundle.
package ppu_bus_pkg;

  localparam int VRAM_AW = 14;

  typedef enum logic [1:0] {
    IDLE,
    ALE,
    STROBE
  } bus_state_t;

  typedef enum logic {
    OWN_RENDER,
    OWN_CPU
  } owner_t;

  typedef struct packed {
    logic               we;
    logic [VRAM_AW-1:0] addr;
    logic [7:0]         wdata;
  } bus_acc_t;

endpackage

// File: rtl/ppu_bus_arb.sv
// Render/CPU arbiter for the PPU VRAM bus.
// Render wins until a pending CPU access has waited STARVE_LIMIT grants.
module ppu_bus_arb #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic n_reset,
  input  logic decide,
  input  logic render_req,
  input  logic cpu_pend,
  output logic grant_render,
  output logic grant_cpu
);

  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;
  logic       starved;

  assign starved      = cpu_pend && (starve_cnt == LIM);
  assign grant_render = decide && render_req && !starved;
  assign grant_cpu    = decide && cpu_pend && !grant_render;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      starve_cnt <= '0;
    end else if (grant_cpu) begin
      starve_cnt <= '0;
    end else if (grant_render && cpu_pend && starve_cnt != LIM) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/ppu_bus_ctrl.sv
// PPU VRAM bus controller: ALE/strobe sequencing of the multiplexed
// AD bus, shared between rendering fetches and CPU $2007 accesses.
module ppu_bus_ctrl
  import ppu_bus_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               n_reset,
  input  logic               render_req,
  input  logic [VRAM_AW-1:0] render_addr,
  output logic               render_ack,
  output logic [7:0]         render_rdata,
  output logic               render_valid,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [VRAM_AW-1:0] cpu_addr,
  input  logic [7:0]         cpu_wdata,
  output logic [7:0]         cpu_rdata,
  output logic               cpu_done,
  output logic               cpu_busy,
  output logic               ale,
  output logic               n_rd,
  output logic               n_wr,
  output logic [5:0]         pa_hi,
  output logic [7:0]         ad_out,
  output logic               ad_oe,
  input  logic [7:0]         ad_in
);

  bus_state_t state;
  owner_t     own;
  bus_acc_t   cur;
  bus_acc_t   pend;
  logic       pend_vld;
  logic       decide;
  logic       grant_render;
  logic       grant_cpu;

  assign decide = (state == IDLE) || (state == STROBE);

  ppu_bus_arb #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arb (
    .clk         (clk),
    .n_reset     (n_reset),
    .decide      (decide),
    .render_req  (render_req),
    .cpu_pend    (pend_vld),
    .grant_render(grant_render),
    .grant_cpu   (grant_cpu)
  );

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state        <= IDLE;
      own          <= OWN_RENDER;
      cur          <= '0;
      pend         <= '0;
      pend_vld     <= 1'b0;
      cpu_busy     <= 1'b0;
      ale          <= 1'b0;
      n_rd         <= 1'b1;
      n_wr         <= 1'b1;
      ad_oe        <= 1'b0;
      ad_out       <= '0;
      pa_hi        <= '0;
      render_ack   <= 1'b0;
      render_valid <= 1'b0;
      render_rdata <= '0;
      cpu_done     <= 1'b0;
      cpu_rdata    <= '0;
    end else begin
      render_ack   <= 1'b0;
      render_valid <= 1'b0;
      cpu_done     <= 1'b0;

      if (cpu_req && !cpu_busy) begin
        pend_vld <= 1'b1;
        pend     <= '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
        cpu_busy <= 1'b1;
      end

      case (state)
        ALE: begin
          state <= STROBE;
          ale   <= 1'b0;
          if (cur.we) begin
            n_wr   <= 1'b0;
            ad_oe  <= 1'b1;
            ad_out <= cur.wdata;
          end else begin
            n_rd  <= 1'b0;
            ad_oe <= 1'b0;
          end
        end
        IDLE, STROBE: begin
          n_rd <= 1'b1;
          n_wr <= 1'b1;
          // Finish the current access on the last STROBE edge.
          if (state == STROBE) begin
            if (own == OWN_RENDER) begin
              render_rdata <= ad_in;
              render_valid <= 1'b1;
            end else begin
              if (!cur.we) cpu_rdata <= ad_in;
              cpu_done <= 1'b1;
              cpu_busy <= 1'b0;
            end
          end
          if (grant_render) begin
            state      <= ALE;
            own        <= OWN_RENDER;
            cur        <= '{we: 1'b0, addr: render_addr, wdata: 8'h00};
            render_ack <= 1'b1;
            ale        <= 1'b1;
            ad_oe      <= 1'b1;
            ad_out     <= render_addr[7:0];
            pa_hi      <= render_addr[13:8];
          end else if (grant_cpu) begin
            state    <= ALE;
            own      <= OWN_CPU;
            cur      <= pend;
            pend_vld <= 1'b0;
            ale      <= 1'b1;
            ad_oe    <= 1'b1;
            ad_out   <= pend.addr[7:0];
            pa_hi    <= pend.addr[13:8];
          end else begin
            state <= IDLE;
            ale   <= 1'b0;
            ad_oe <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          ale   <= 1'b0;
          ad_oe <= 1'b0;
          n_rd  <= 1'b1;
          n_wr  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ppu_bus_ctrl.sv
// Directed bench for ppu_bus_ctrl: render read, CPU read/write,
// busy-drop, starvation limit and mid-access reset.
module tb_ppu_bus_ctrl;

  logic        clk;
  logic        n_reset;
  logic        render_req;
  logic [13:0] render_addr;
  logic        render_ack;
  logic [7:0]  render_rdata;
  logic        render_valid;
  logic        cpu_req;
  logic        cpu_we;
  logic [13:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_done;
  logic        cpu_busy;
  logic        ale;
  logic        n_rd;
  logic        n_wr;
  logic [5:0]  pa_hi;
  logic [7:0]  ad_out;
  logic        ad_oe;
  logic [7:0]  ad_in;

  int n_checks = 0;
  int n_errors = 0;

  ppu_bus_ctrl #(.STARVE_LIMIT(4)) dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .render_req  (render_req),
    .render_addr (render_addr),
    .render_ack  (render_ack),
    .render_rdata(render_rdata),
    .render_valid(render_valid),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_done    (cpu_done),
    .cpu_busy    (cpu_busy),
    .ale         (ale),
    .n_rd        (n_rd),
    .n_wr        (n_wr),
    .pa_hi       (pa_hi),
    .ad_out      (ad_out),
    .ad_oe       (ad_oe),
    .ad_in       (ad_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_pulse(input logic we, input logic [13:0] a,
                           input logic [7:0] d);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = d;
    tick();
    cpu_req = 1'b0;
  endtask

  initial begin
    int nrend;
    int ndone;
    int cpu_at;
    int next_at;
    logic armed;
    logic cpu_seen;

    n_reset     = 1'b0;
    render_req  = 1'b0;
    render_addr = '0;
    cpu_req     = 1'b0;
    cpu_we      = 1'b0;
    cpu_addr    = '0;
    cpu_wdata   = '0;
    ad_in       = '0;

    #12;
    check("rst_ale", ale, 0);
    check("rst_nrd", n_rd, 1);
    check("rst_nwr", n_wr, 1);
    check("rst_oe", ad_oe, 0);
    check("rst_pahi", pa_hi, 0);
    check("rst_busy", cpu_busy, 0);
    check("rst_done", cpu_done, 0);
    check("rst_valid", render_valid, 0);
    #5 n_reset = 1'b1;
    tick();
    tick();

    // Render read 0x2345, ad_in 0xA5
    render_req  = 1'b1;
    render_addr = 14'h2345;
    tick();
    check("r_ale", ale, 1);
    check("r_ack", render_ack, 1);
    check("r_adout", ad_out, 8'h45);
    check("r_pahi", pa_hi, 6'h23);
    check("r_oe_ale", ad_oe, 1);
    check("r_nrd_ale", n_rd, 1);
    render_req = 1'b0;
    ad_in      = 8'hA5;
    tick();
    check("r_nrd", n_rd, 0);
    check("r_oe_strb", ad_oe, 0);
    check("r_ale_strb", ale, 0);
    check("r_pahi_hold", pa_hi, 6'h23);
    check("r_ack_off", render_ack, 0);
    tick();
    check("r_valid", render_valid, 1);
    check("r_rdata", render_rdata, 8'hA5);
    check("r_nrd_off", n_rd, 1);
    check("r_oe_idle", ad_oe, 0);
    tick();
    check("r_valid_off", render_valid, 0);
    check("r_idle_ale", ale, 0);

    // CPU read 0x0123 with a second request while busy
    cpu_pulse(1'b0, 14'h0123, 8'h00);
    check("c_busy", cpu_busy, 1);
    check("c_noale", ale, 0);
    cpu_pulse(1'b1, 14'h0456, 8'h99);
    check("c_ale", ale, 1);
    check("c_noack", render_ack, 0);
    check("c_adout", ad_out, 8'h23);
    check("c_pahi", pa_hi, 6'h01);
    ad_in = 8'h5A;
    tick();
    check("c_nrd", n_rd, 0);
    check("c_nwr", n_wr, 1);
    tick();
    check("c_done", cpu_done, 1);
    check("c_rdata", cpu_rdata, 8'h5A);
    check("c_busy_off", cpu_busy, 0);
    ndone = 0;
    armed = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cpu_done) ndone++;
      if (ale) armed = 1'b1;
    end
    check("c_second_done", ndone, 0);
    check("c_second_ale", armed, 0);

    // CPU write 0x3F00 <= 0x1C
    cpu_pulse(1'b1, 14'h3F00, 8'h1C);
    check("w_busy", cpu_busy, 1);
    tick();
    check("w_ale", ale, 1);
    check("w_adout_a", ad_out, 8'h00);
    check("w_pahi", pa_hi, 6'h3F);
    tick();
    check("w_nwr", n_wr, 0);
    check("w_nrd", n_rd, 1);
    check("w_oe", ad_oe, 1);
    check("w_adout_d", ad_out, 8'h1C);
    tick();
    check("w_done", cpu_done, 1);
    check("w_busy_off", cpu_busy, 0);
    check("w_nwr_off", n_wr, 1);
    check("w_rdata_keep", cpu_rdata, 8'h5A);
    tick();
    check("w_done_off", cpu_done, 0);

    // Starvation: continuous render plus one CPU read
    render_req  = 1'b1;
    render_addr = 14'h1000;
    tick();
    tick();
    tick();
    cpu_pulse(1'b0, 14'h2ABC, 8'h00);
    nrend    = 0;
    armed    = 1'b0;
    cpu_seen = 1'b0;
    cpu_at   = 0;
    next_at  = 0;
    if (cpu_busy) armed = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (armed && ale && next_at == 0) begin
        if (cpu_seen) begin
          if (render_ack) next_at = i;
        end else if (render_ack) begin
          nrend++;
        end else begin
          cpu_seen = 1'b1;
          cpu_at   = i;
          check("s_cpu_pahi", pa_hi, 6'h2A);
        end
      end
      if (cpu_busy) armed = 1'b1;
    end
    check("s_cpu_seen", cpu_seen, 1);
    check("s_nrender", nrend, 4);
    check("s_resume_gap", next_at - cpu_at, 2);
    render_req = 1'b0;
    tick();
    tick();
    tick();
    tick();
    check("s_drain_ale", ale, 0);
    check("s_drain_busy", cpu_busy, 0);

    // Reset during STROBE of a CPU read
    cpu_pulse(1'b0, 14'h0077, 8'h00);
    tick();
    tick();
    check("x_nrd", n_rd, 0);
    #1 n_reset = 1'b0;
    #1;
    check("x_nrd_rst", n_rd, 1);
    check("x_busy_rst", cpu_busy, 0);
    #3 n_reset = 1'b1;
    ndone = 0;
    armed = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (cpu_done) ndone++;
      if (ale) armed = 1'b1;
    end
    check("x_nodone", ndone, 0);
    check("x_noale", armed, 0);
    check("x_busy", cpu_busy, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ppu_bus_ctrl.md
PPU_BUS_CTRL -- requirements
Module: ppu_bus_ctrl

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4, range 1..15: consecutive render grants a pending CPU access waits before it is forced.
REQ-002 The block SHALL have port clk, input, 1: single clock; one clk cycle equals one PPU dot.
REQ-003 The block SHALL have port n_reset, input, 1: asynchronous, active-low reset.
REQ-004 The block SHALL have port render_req, input, 1: rendering fetch request, level, held until render_ack.
REQ-005 The block SHALL have port render_addr, input, 14: rendering VRAM address.
REQ-006 The block SHALL have port render_ack, output, 1: one-cycle pulse in the ALE cycle of a granted render access.
REQ-007 The block SHALL have ports render_rdata, output, 8, and render_valid, output, 1: read data, qualified by a one-cycle valid pulse.
REQ-008 The block SHALL have port cpu_req, input, 1: one-cycle $2007 access pulse.
REQ-009 The block SHALL have ports cpu_we, input, 1; cpu_addr, input, 14; cpu_wdata, input, 8: access qualifiers, sampled with cpu_req.
REQ-010 The block SHALL have ports cpu_rdata, output, 8; cpu_done, output, 1; cpu_busy, output, 1: read data, a one-cycle completion pulse, and a pending-or-active flag.
REQ-011 The block SHALL have port ale, output, 1: address latch enable to the external LS373 latch.
REQ-012 The block SHALL have ports n_rd, output, 1, and n_wr, output, 1: active-low VRAM strobes.
REQ-013 The block SHALL have port pa_hi, output, 6: VRAM address bits 13:8.
REQ-014 The block SHALL have ports ad_out, output, 8; ad_oe, output, 1; ad_in, input, 8: multiplexed AD bus, with the tristate resolved at top level.

Function
REQ-015 The FSM SHALL have states IDLE, ALE and STROBE, with every output registered.
REQ-016 In ALE the block SHALL drive ale=1, ad_oe=1, ad_out=addr[7:0], pa_hi=addr[13:8] and n_rd=n_wr=1.
REQ-017 In STROBE the block SHALL drive ale=0 and hold pa_hi; for a read: n_rd=0 and ad_oe=0; for a write: n_wr=0, ad_oe=1 and ad_out=wdata.
REQ-018 For a read, the block SHALL sample ad_in on the last clk edge of STROBE, and SHALL pulse render_valid or cpu_done with the data in the following cycle (two-cycle access, read latency 3 from grant).
REQ-019 For a write, the block SHALL pulse cpu_done in the cycle after STROBE, and cpu_rdata SHALL be left unchanged.
REQ-020 Render accesses SHALL always be reads.
REQ-021 A cpu_req pulse SHALL set a pending register capturing cpu_we, cpu_addr and cpu_wdata; cpu_busy SHALL be 1 from the next cycle until cpu_done.
REQ-022 A cpu_req arriving while cpu_busy=1 SHALL be ignored.
REQ-023 Arbitration SHALL be evaluated in IDLE and in the last STROBE cycle; the transition from STROBE to ALE SHALL be back-to-back with no idle cycle.
REQ-024 Render SHALL win unless no render_req is present or starve_cnt==STARVE_LIMIT, in which case the pending CPU access SHALL win.
REQ-025 starve_cnt (4 bits) SHALL increment on each render grant while CPU is pending, SHALL clear on CPU grant, and SHALL saturate at STARVE_LIMIT.
REQ-026 If cpu_req and a grant decision coincide, the new request SHALL become pending in the next cycle and SHALL NOT be granted in the same cycle.
REQ-027 With no requests pending, the FSM SHALL return to IDLE with all strobes inactive and ad_oe=0.

Reset
REQ-028 While n_reset=0, the block SHALL force state=IDLE, ale=0, n_rd=1, n_wr=1, ad_oe=0, ad_out=0, pa_hi=0, all ack/valid/done=0, rdata registers=0, pending=0, cpu_busy=0 and starve_cnt=0.
REQ-029 Reset asserted mid-access SHALL deassert strobes immediately, SHALL drop any pending CPU request, and SHALL produce no done or valid pulse.

Structure
REQ-030 Package ppu_bus_pkg SHALL hold typedef enum bus_state_t {IDLE, ALE, STROBE}, VRAM_AW=14 and the owner enum {OWN_RENDER, OWN_CPU}.
REQ-031 The arbitration logic (grant decision plus starve_cnt) SHALL be a single sub-module, ppu_bus_arb; the FSM and pads SHALL stay in ppu_bus_ctrl.

Verification
REQ-032 Render read at 0x2345 with ad_in=0xA5 during STROBE -> ale=1 with ad_out=0x45 and pa_hi=0x23, next n_rd=0, next render_valid=1 with render_rdata=0xA5.
REQ-033 CPU write addr 0x3F00 data 0x1C in idle -> ALE then n_wr=0 with ad_out=0x1C and ad_oe=1, cpu_done one cycle later, cpu_busy cleared.
REQ-034 render_req held continuously plus one cpu_req, STARVE_LIMIT=4 -> exactly 4 render grants, then CPU grant, then render resumes.
REQ-035 Second cpu_req while busy -> ignored, single cpu_done only.
REQ-036 n_reset pulsed low during STROBE of a CPU read -> n_rd=1 immediately, no cpu_done, cpu_busy=0 after release.
